// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port byte-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    localparam int WORD_BEATS = 4;
    localparam int BYTE_LANE  = 8;

    // Replace one big-endian byte lane of a word (beat 0 = bits 31:24).
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  beat,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (beat)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

    // Extract one big-endian byte lane of a word (beat 0 = bits 31:24).
    function automatic logic [7:0] get_lane(input logic [31:0] word,
                                            input logic [1:0]  beat);
        logic [7:0] b;
        case (beat)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and byte-memory signals of the memory port arbiter.
// Handshake: a requester raises req with its inputs stable and holds them
// until it sees the one-cycle done pulse; err qualifies done and rdata is
// valid from done until the next done of the same port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_writeData;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [7:0]        mem_readData;

    // Requesters and memory model side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_readData,
        input  if_done, if_rdata, if_err, d_done, d_rdata, d_err,
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_readData,
        output if_done, if_rdata, if_err, d_done, d_rdata, d_err,
        output mem_address, mem_writeData, mem_memWrite, mem_memRead
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant between fetch and data requests.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   grant_en,
    input  logic   req_fetch,
    input  logic   req_data,
    output logic   grant_valid,
    output owner_t grant_owner,
    output owner_t last_grant
);

    // Remember who won last so a tie goes to the other port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_DATA;
        end else if (grant_valid) begin
            last_grant <= grant_owner;
        end
    end

    // Single request wins outright; a tie alternates.
    always_comb begin
        grant_valid = grant_en && (req_fetch || req_data);
        grant_owner = OWN_DATA;
        if (req_fetch && req_data) begin
            grant_owner = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (req_fetch) begin
            grant_owner = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between the fetch port and the data port,
// sequencing word accesses as four big-endian byte beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
)(
    input  logic             clock,
    input  logic             reset,
    mem_port_arbiter_if.slave bus,
    output state_t           dbg_state,
    output logic [1:0]       dbg_beat,
    output owner_t           dbg_last_grant
);

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic [ADDR_W-1:0] base;
    logic              we;
    logic              is_byte;
    logic [31:0]       wdata;
    logic [31:0]       rd_buf;
    logic [1:0]        beat;

    logic              grant_valid;
    owner_t            grant_owner;
    owner_t            last_grant;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_byte;
    logic              sel_we;
    logic [ADDR_W:0]   len_m1;
    logic [ADDR_W:0]   sel_last;
    logic              sel_err;
    logic              last_beat;
    logic [31:0]       rd_word;

    mem_arb_rr u_rr (
        .clock       (clock),
        .reset       (reset),
        .grant_en    (state == ST_IDLE),
        .req_fetch   (bus.if_req),
        .req_data    (bus.d_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner),
        .last_grant  (last_grant)
    );

    assign dbg_state      = state;
    assign dbg_beat       = beat;
    assign dbg_last_grant = last_grant;

    // Decode the granted request and range-check it; the sum is one bit wider
    // so an address near the top of the space cannot wrap past the check.
    always_comb begin
        sel_addr  = (grant_owner == OWN_FETCH) ? bus.if_addr : bus.d_addr;
        sel_byte  = (grant_owner == OWN_FETCH) ? 1'b0 : bus.d_byte;
        sel_we    = (grant_owner == OWN_FETCH) ? 1'b0 : bus.d_we;
        len_m1    = sel_byte ? '0 : (ADDR_W+1)'(WORD_BEATS - 1);
        sel_last  = {1'b0, sel_addr} + len_m1;
        sel_err   = (!sel_byte && (sel_addr[1:0] != 2'b00)) ||
                    (sel_last >= (ADDR_W+1)'(MEM_BYTES));
        last_beat = is_byte || (beat == 2'(WORD_BEATS - 1));
        rd_word   = put_lane(rd_buf, beat, bus.mem_readData);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory strobes; memory is only touched in BEAT.
    always_comb begin
        state_next        = state;
        bus.mem_address   = '0;
        bus.mem_writeData = 8'h00;
        bus.mem_memWrite  = 1'b0;
        bus.mem_memRead   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = sel_err ? ST_DONE : ST_BEAT;
                end
            end
            ST_BEAT: begin
                bus.mem_address = base + ADDR_W'(beat);
                if (we) begin
                    bus.mem_memWrite  = 1'b1;
                    bus.mem_writeData = is_byte ? wdata[7:0] : get_lane(wdata, beat);
                end else begin
                    bus.mem_memRead = 1'b1;
                end
                if (last_beat) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch the granted request, gather read bytes, and raise the owner's
    // done/err/rdata on the edge that enters DONE so they are valid together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner        <= OWN_DATA;
            base         <= '0;
            we           <= 1'b0;
            is_byte      <= 1'b0;
            wdata        <= '0;
            rd_buf       <= '0;
            beat         <= 2'd0;
            bus.if_done  <= 1'b0;
            bus.if_err   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_done   <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_done <= 1'b0;
            bus.if_err  <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.d_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner   <= grant_owner;
                        base    <= sel_addr;
                        we      <= sel_we;
                        is_byte <= sel_byte;
                        wdata   <= bus.d_wdata;
                        beat    <= 2'd0;
                        rd_buf  <= '0;
                        if (sel_err) begin
                            if (grant_owner == OWN_FETCH) begin
                                bus.if_done <= 1'b1;
                                bus.if_err  <= 1'b1;
                            end else begin
                                bus.d_done <= 1'b1;
                                bus.d_err  <= 1'b1;
                            end
                        end
                    end
                end
                ST_BEAT: begin
                    if (!we) begin
                        rd_buf <= rd_word;
                    end
                    if (last_beat) begin
                        if (owner == OWN_FETCH) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= rd_word;
                        end else begin
                            bus.d_done <= 1'b1;
                            if (!we) begin
                                bus.d_rdata <= is_byte ?
                                    {{24{bus.mem_readData[7]}}, bus.mem_readData} : rd_word;
                            end
                        end
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide main memory between two requesters: the instruction-fetch port (IF, 32-bit word reads only) and the data port (MEM, word or byte, read or write).
- Each word access is sequenced as four byte beats in big-endian order. Results are returned to the requester with a one-cycle done pulse.
- Sits between the IF/MEM pipeline stages and the byte memory. The pipeline stalls on req && !done.

Parameters:
- MEM_BYTES, 1024, number of addressable bytes; any address >= MEM_BYTES is out of range.
- ADDR_W, 32, address width of requesters and memory.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetched word; valid from if_done, held until the next if_done
- if_err  out  1  qualifies if_done: misaligned or out-of-range access
- d_req  in  1  data request; held high with d_* inputs stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_byte  in  1  1 = byte access, 0 = word access
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  write data; byte write uses [7:0]
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  read result; byte read is sign-extended from bit 7; held until the next d_done
- d_err  out  1  qualifies d_done: misaligned or out-of-range access
- mem_address  out  ADDR_W  byte address to memory
- mem_writeData  out  8  byte to memory
- mem_memWrite  out  1  memory write enable
- mem_memRead  out  1  memory read enable
- mem_readData  in  8  combinational read data from memory

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, beat=0, last_grant=DATA.
  - All done/err pulses = 0; if_rdata = d_rdata = 0.
  - mem_memWrite = mem_memRead = 0; mem_address = 0; mem_writeData = 0.
- States: IDLE, BEAT, DONE.
- IDLE:
  - Arbitration: if exactly one request is pending, grant it. If both are pending, grant the port not in last_grant (round-robin).
  - On grant: latch owner, addr, we, size, and wdata; update last_grant; set beat=0.
  - Error check: err when a word access has addr[1:0] != 0, or when addr+len-1 >= MEM_BYTES (len = 4 for word, 1 for byte).
  - On error: go to DONE with err set; no memory beats are issued.
  - Otherwise go to BEAT.
- BEAT (one cycle per byte):
  - mem_address = base + beat.
  - Read: mem_memRead = 1. At the clock edge, mem_readData is captured into byte lane (31-8*beat).
  - Write: mem_memWrite = 1; mem_writeData = wdata[31-8*beat -: 8]. A byte write uses wdata[7:0].
  - The final beat (beat=3 for word, 0 for byte) transitions to DONE; otherwise beat increments.
- DONE (one cycle):
  - Pulse the owner's done output and drive its err. Update the owner's rdata output register (byte reads sign-extended; unchanged on write or err).
  - Return to IDLE.
  - The requester drops or changes req in the cycle after done. A req still high in IDLE is treated as a new request.
- Latency from the req-sampled cycle to the done cycle: word = 5 cycles, byte = 2 cycles, err = 1 cycle.
- Outside BEAT, mem_memRead = mem_memWrite = 0, mem_address = 0, mem_writeData = 0. The memory is never read and written in the same cycle.
- Back-to-back throughput: one word per 6 cycles (IDLE + 4 beats + DONE).
- Input changes during BEAT are ignored; latched copies are used.
- Reset mid-transaction:
  - Aborts immediately; no done pulse is issued.
  - mem_memWrite drops asynchronously.
  - Bytes already written stay in memory.
- Arithmetic: base + beat is computed in ADDR_W bits and cannot overflow after the range check.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE/BEAT/DONE)
  - owner encoding (DATA/FETCH)
  - WORD_BEATS = 4, BYTE_LANE = 8
- One natural sub-module: mem_arb_rr, the two-way round-robin grant logic with the last_grant register.

Test Plan:
- Memory preloaded mem[i] = i[7:0]. Fetch at 0x10 -> if_done in cycle 5, if_rdata = 0x10111213, if_err = 0. Verify mem_address sequence 0x10, 0x11, 0x12, 0x13 with mem_memRead high for exactly 4 cycles.
- Data word write at 0x20 with d_wdata = 0xDEADBEEF, then word read at 0x20 -> mem bytes 0x20..0x23 = DE, AD, BE, EF; d_rdata = 0xDEADBEEF.
- Byte read at 0x85 (value 0x85) -> d_rdata = 0xFFFFFF85. Byte read at 0x05 -> d_rdata = 0x00000005. Both complete in 2 cycles.
- if_req and d_req raised together from reset -> FETCH granted first (last_grant=DATA), then DATA. With both held high continuously, grants alternate F, D, F, D.
- Errors, each producing err=1 and done one cycle after grant with no mem_memRead/mem_memWrite activity:
  - word read at 0x22 (misaligned)
  - word read at 0x3FE
  - byte read at 0x400
- Assert reset during beat 2 of a word write at 0x40 -> mem_memWrite falls immediately. mem[0x40..0x41] hold the new bytes, mem[0x42..0x43] are unchanged, and no d_done pulse occurs.
